// File: rtl/fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared core definitions for the instruction fetch slice:
//   FETCH_ADDRWIDTH  default width of PC / instruction memory address
//   FETCH_RESET_PC   default first fetch byte address after reset
//   fetch_entry_t    one buffered instruction {pc, instr}
//   fetch_state_t    fetch control FSM encoding
// ----------------------------------------------------------------------------
package fetch_unit_pkg;

   localparam int                         FETCH_ADDRWIDTH = 32;
   localparam logic [FETCH_ADDRWIDTH-1:0] FETCH_RESET_PC  = 32'h0000_0000;

   // Depth of the decoupling buffer between memory and decode. Two entries
   // are what a one-cycle memory needs to sustain one instruction per cycle.
   localparam logic [1:0] FETCH_FIFO_DEPTH = 2'd2;

   // The pc field is sized by the package default; the top converts to and
   // from its own ADDRWIDTH when writing and reading entries.
   typedef struct packed {
      logic [FETCH_ADDRWIDTH-1:0] pc;
      logic [31:0]                instr;
   } fetch_entry_t;

   typedef enum logic {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// Two-entry instruction buffer. Entry 0 is always the head.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   push        write push_entry this cycle
//   pop         remove the head this cycle
//   flush       drop all entries (wins over push and pop)
//   push_entry  {pc, instr} to store
//   count       number of valid entries (0..2)
//   head        oldest entry; zero after reset
// ----------------------------------------------------------------------------
module fetch_fifo
   import fetch_unit_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t push_entry,
   output logic [1:0]   count,
   output fetch_entry_t head
);

   fetch_entry_t ent0;
   fetch_entry_t ent1;

   assign head = ent0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= 2'd0;
         ent0  <= '0;
         ent1  <= '0;
      end else if (flush) begin
         count <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count != FETCH_FIFO_DEPTH) begin
                  if (count == 2'd0) ent0 <= push_entry;
                  else               ent1 <= push_entry;
                  count <= count + 2'd1;
               end
            end
            2'b01: begin
               if (count != 2'd0) begin
                  ent0  <= ent1;
                  count <= count - 2'd1;
               end
            end
            2'b11: begin
               // The issuer never lets push and pop meet at a full buffer,
               // so with one entry the new word simply replaces the head.
               // The full-buffer branch is kept as a plain shift for safety.
               if (count == 2'd1) begin
                  ent0 <= push_entry;
               end else if (count == 2'd0) begin
                  ent0  <= push_entry;
                  count <= 2'd1;
               end else begin
                  ent0 <= ent1;
                  ent1 <= push_entry;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch front end. Issues word reads to a memory whose data is
// valid the cycle after rd_addr is registered, buffers up to two fetched
// instructions and hands them to decode with a valid/ready handshake.
//
// Handshake: out_valid depends only on registered state and, once high,
// out_pc/out_instr hold until out_valid && out_ready is seen at a rising
// edge (the transfer); a redirect may retract out_valid by flushing.
//
// Ports:
//   clk             clock, all state on rising edge
//   cpu_rst         asynchronous active-high reset
//   rd_addr         registered memory word address (pc >> 2)
//   rd_data         memory read data for the previous cycle's rd_addr
//   redirect_valid  restart fetching at redirect_pc (bits [1:0] ignored)
//   redirect_pc     new fetch byte address
//   out_valid       out_instr/out_pc hold a valid instruction
//   out_ready       decode accepts the instruction
//   out_instr       fetched instruction word
//   out_pc          byte address of out_instr
// ----------------------------------------------------------------------------
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                   ADDRWIDTH = FETCH_ADDRWIDTH,
   parameter logic [ADDRWIDTH-1:0] RESET_PC  = ADDRWIDTH'(FETCH_RESET_PC)
) (
   input  logic                 clk,
   input  logic                 cpu_rst,
   output logic [ADDRWIDTH-1:0] rd_addr,
   input  logic [31:0]          rd_data,
   input  logic                 redirect_valid,
   input  logic [ADDRWIDTH-1:0] redirect_pc,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_instr,
   output logic [ADDRWIDTH-1:0] out_pc
);

   localparam logic [ADDRWIDTH-1:0] PC_STEP    = ADDRWIDTH'(4);
   localparam logic [ADDRWIDTH-1:0] ALIGN_MASK = ~ADDRWIDTH'(3);

   fetch_state_t         state;
   fetch_state_t         state_nxt;

   logic [ADDRWIDTH-1:0] req_pc;
   logic [ADDRWIDTH-1:0] inflight_pc;
   logic                 inflight;

   logic                 issue;
   logic [ADDRWIDTH-1:0] issue_pc;
   logic                 pop;
   logic                 push;
   logic                 flush;
   logic [2:0]           occupancy;
   logic [1:0]           fifo_count;
   fetch_entry_t         push_entry;
   fetch_entry_t         head_entry;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge cpu_rst) begin
      if (cpu_rst) state <= ST_BOOT;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_BOOT: state_nxt = ST_RUN;
         ST_RUN:  state_nxt = ST_RUN;
         default: state_nxt = ST_BOOT;
      endcase
   end

   // ------------------------------------------------------- issue control
   always_comb begin
      pop       = out_valid & out_ready;
      // Slots already committed after this cycle's pop: buffered words plus
      // the word arriving from memory now. A new request needs a free slot.
      occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
      issue     = (occupancy < 3'd2);
      issue_pc  = req_pc;
      if (state == ST_BOOT) begin
         issue    = 1'b1;
         issue_pc = RESET_PC;
      end
      if (redirect_valid) begin
         issue    = 1'b1;
         issue_pc = redirect_pc & ALIGN_MASK;
      end
      // The word returning during a redirect belongs to the old stream.
      flush            = redirect_valid;
      push             = inflight & ~redirect_valid;
      push_entry.pc    = FETCH_ADDRWIDTH'(inflight_pc);
      push_entry.instr = rd_data;
   end

   always_ff @(posedge clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         req_pc      <= RESET_PC;
         rd_addr     <= RESET_PC >> 2;
         inflight    <= 1'b0;
         inflight_pc <= RESET_PC;
      end else begin
         inflight <= issue;
         if (issue) begin
            rd_addr     <= issue_pc >> 2;
            inflight_pc <= issue_pc;
            req_pc      <= issue_pc + PC_STEP;
         end
      end
   end

   // ------------------------------------------------------------ buffer
   fetch_fifo u_fifo (
      .clk        (clk),
      .rst        (cpu_rst),
      .push       (push),
      .pop        (pop),
      .flush      (flush),
      .push_entry (push_entry),
      .count      (fifo_count),
      .head       (head_entry)
   );

   assign out_valid = (fifo_count != 2'd0);
   assign out_instr = head_entry.instr;
   assign out_pc    = ADDRWIDTH'(head_entry.pc);

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. Memory word i holds 32'h1000_0000 + i and
// answers the address registered at the previous edge. Every delivered
// instruction is compared against an expected {pc, instr} queue that is
// refilled whenever the stream restarts (reset or redirect).
// ----------------------------------------------------------------------------
module tb_fetch_unit;

   localparam int W = 64;

   logic        clk = 1'b0;
   logic        cpu_rst;
   logic [31:0] rd_addr;
   logic [31:0] rd_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;

   logic [31:0] mem [0:1023];

   logic [W-1:0] exp_q[$];
   int           checks    = 0;
   int           failures  = 0;
   int           delivered = 0;

   logic         s_valid;
   logic [31:0]  s_pc;

   fetch_unit dut (
      .clk            (clk),
      .cpu_rst        (cpu_rst),
      .rd_addr        (rd_addr),
      .rd_data        (rd_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc)
   );

   // ------------------------------------------------- clock and memory
   always #5 clk = ~clk;

   assign rd_data = mem[rd_addr[9:0]];

   // --------------------------------------------------------- helpers
   function automatic logic [31:0] model_instr(input logic [31:0] pc);
      return 32'h1000_0000 + {22'd0, pc[11:2]};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // New expected stream: whatever was still queued is gone with the flush.
   task automatic restart_sb(input logic [31:0] start, input int n);
      logic [31:0] pc;
      exp_q.delete();
      delivered = 0;
      for (int i = 0; i < n; i++) begin
         pc = start + 32'(4 * i);
         exp_q.push_back({pc, model_instr(pc)});
      end
   endtask

   // One clock: sample at the falling edge, score any transfer, then return
   // just after the next rising edge so the caller can drive new inputs.
   task automatic tick();
      logic [W-1:0] e;
      @(negedge clk);
      s_valid = out_valid;
      s_pc    = out_pc;
      if (out_valid && out_ready) begin
         delivered++;
         checks++;
         assert (exp_q.size() != 0)
         else begin
            failures++;
            $error("FAIL sb_underflow: observed pc=%0h expected none", out_pc);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_pc", out_pc, e[63:32]);
            check("sb_instr", out_instr, e[31:0]);
         end
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------- stimulus
   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + 32'(i);
      cpu_rst        = 1'b1;
      out_ready      = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;

      // Reset values
      tick();
      tick();
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_rd_addr", rd_addr, 32'h0);
      check("rst_out_pc", out_pc, 32'h0);
      check("rst_out_instr", out_instr, 32'h0);

      // Streaming from reset: first valid in cycle 2, then one per cycle
      cpu_rst = 1'b0;
      restart_sb(32'h0, 16);
      for (int c = 0; c < 12; c++) begin
         tick();
         check("boot_valid", s_valid, (c >= 2));
      end
      check("boot_delivered", delivered, 10);

      // Reset mid-stream clears outputs at once, restarts at RESET_PC
      cpu_rst = 1'b1;
      #1;
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_out_pc", out_pc, 32'h0);
      check("midrst_rd_addr", rd_addr, 32'h0);
      tick();
      tick();
      cpu_rst = 1'b0;
      restart_sb(32'h0, 16);
      for (int c = 0; c < 6; c++) begin
         tick();
         check("midrst_valid", s_valid, (c >= 2));
      end
      check("midrst_delivered", delivered, 4);

      // Decode stalls for 5 cycles after the first valid
      cpu_rst = 1'b1;
      tick();
      cpu_rst   = 1'b0;
      out_ready = 1'b0;
      restart_sb(32'h0, 16);
      tick();
      tick();
      for (int c = 0; c < 5; c++) begin
         tick();
         check("stall_valid", s_valid, 1'b1);
         check("stall_pc", s_pc, 32'h0);
      end
      out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         check("resume_valid", s_valid, 1'b1);
      end
      check("resume_delivered", delivered, 6);

      // Redirect while the buffer is full of the old stream
      cpu_rst   = 1'b1;
      out_ready = 1'b0;
      tick();
      cpu_rst = 1'b0;
      restart_sb(32'h0, 4);
      for (int c = 0; c < 4; c++) tick();
      check("full_valid", s_valid, 1'b1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0100;
      tick();
      redirect_valid = 1'b0;
      restart_sb(32'h100, 16);
      tick();
      check("redir_gap_valid", s_valid, 1'b0);
      out_ready = 1'b1;
      for (int c = 0; c < 6; c++) tick();
      check("redir_delivered", delivered, 6);

      // Back-to-back redirects while streaming; the redirect-cycle transfer
      // of the old head is scored against the old stream
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0040;
      tick();
      redirect_pc = 32'h0000_0080;
      tick();
      check("b2b_valid_r2", s_valid, 1'b0);
      redirect_valid = 1'b0;
      restart_sb(32'h80, 16);
      tick();
      check("b2b_valid_gap", s_valid, 1'b0);
      for (int c = 0; c < 5; c++) tick();
      check("b2b_delivered", delivered, 5);

      // Misaligned redirect target is forced to a word boundary
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0103;
      tick();
      redirect_valid = 1'b0;
      restart_sb(32'h100, 8);
      check("misalign_rd_addr", rd_addr, 32'h40);
      for (int c = 0; c < 4; c++) tick();
      check("misalign_delivered", delivered, 3);

      // Fetch address wraps from the top of the address space to 0
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFF8;
      tick();
      redirect_valid = 1'b0;
      restart_sb(32'hFFFF_FFF8, 4);
      check("wrap_rd_addr", rd_addr, 32'h3FFF_FFFE);
      for (int c = 0; c < 5; c++) tick();
      check("wrap_delivered", delivered, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
